// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute hazard inputs and the pipeline
// stall/flush controls plus the lost-cycle performance counter.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] rs1_id;
    logic [REG_W-1:0] rs2_id;
    logic             rs2_used_id;
    logic [REG_W-1:0] rd_ex;
    logic             wbs_ex;
    logic             mm_ex;
    logic             branch_taken_ex;
    logic             mem_busy;
    logic             stall_fd;
    logic             flush_fd;
    logic             stall_de;
    logic             flush_de;
    logic             stall_em;
    logic [CNT_W-1:0] lost_cycles;

    // Pipeline side: supplies hazard information, consumes controls.
    modport master (
        output rs1_id, rs2_id, rs2_used_id, rd_ex, wbs_ex, mm_ex,
               branch_taken_ex, mem_busy,
        input  stall_fd, flush_fd, stall_de, flush_de, stall_em, lost_cycles
    );

    // Controller side.
    modport slave (
        input  rs1_id, rs2_id, rs2_used_id, rd_ex, wbs_ex, mm_ex,
               branch_taken_ex, mem_busy,
        output stall_fd, flush_fd, stall_de, flush_de, stall_em, lost_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 16-bit pipelined CPU.
// Mealy stall/flush controls for load-use, taken-branch and memory-wait
// hazards, plus a saturating count of lost (stalled or flushed) cycles.
module pipeline_hazard_ctrl #(
    parameter int REG_W      = 4,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam int BW = 3;  // enough for up to 7 bubbles

    typedef enum logic [1:0] {
        S_RUN,
        S_LOAD_STALL,
        S_MEM_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    bub_q, bub_d;
    logic [CNT_W-1:0] lost_q;

    logic [REG_W-1:0] rs1_id, rs2_id, rd_ex;
    logic             lu;
    logic             stall_fd_c, flush_fd_c, stall_de_c, flush_de_c, stall_em_c;
    logic             lost_inc;

    assign rs1_id = bus.rs1_id;
    assign rs2_id = bus.rs2_id;
    assign rd_ex  = bus.rd_ex;

    // Load in execute whose destination is read by the instruction in decode.
    assign lu = bus.mm_ex & bus.wbs_ex & (rd_ex != '0) &
                ((rd_ex == rs1_id) | (bus.rs2_used_id & (rd_ex == rs2_id)));

    // Next-state and control decode; priority is mem_busy > branch > load-use.
    always_comb begin
        state_d    = state_q;
        bub_d      = bub_q;
        stall_fd_c = 1'b0;
        flush_fd_c = 1'b0;
        stall_de_c = 1'b0;
        flush_de_c = 1'b0;
        stall_em_c = 1'b0;
        unique case (state_q)
            // RUN and the release cycle of MEM_WAIT are evaluated the same way;
            // in RUN the bubble counter is always zero, so the fall-through
            // target below only differs when a wait interrupted a load stall.
            S_RUN, S_MEM_WAIT: begin
                if (bus.mem_busy) begin
                    stall_fd_c = 1'b1;
                    stall_de_c = 1'b1;
                    stall_em_c = 1'b1;
                    state_d    = S_MEM_WAIT;
                end else if (bus.branch_taken_ex) begin
                    flush_fd_c = 1'b1;
                    flush_de_c = 1'b1;
                    bub_d      = '0;
                    state_d    = S_RUN;
                end else if (lu) begin
                    stall_fd_c = 1'b1;
                    flush_de_c = 1'b1;
                    bub_d      = BW'(LOAD_STALL - 1);
                    state_d    = (LOAD_STALL > 1) ? S_LOAD_STALL : S_RUN;
                end else begin
                    state_d = (bub_q != '0) ? S_LOAD_STALL : S_RUN;
                end
            end
            S_LOAD_STALL: begin
                if (bus.mem_busy) begin
                    // Counter is left untouched so bubbles resume after the wait.
                    stall_fd_c = 1'b1;
                    stall_de_c = 1'b1;
                    stall_em_c = 1'b1;
                    state_d    = S_MEM_WAIT;
                end else if (bus.branch_taken_ex) begin
                    flush_fd_c = 1'b1;
                    flush_de_c = 1'b1;
                    bub_d      = '0;
                    state_d    = S_RUN;
                end else begin
                    stall_fd_c = 1'b1;
                    flush_de_c = 1'b1;
                    if (bub_q <= 3'd1) begin
                        bub_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        bub_d = bub_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_RUN;
                bub_d   = '0;
            end
        endcase
    end

    // Controls are forced low for as long as reset is held.
    assign bus.stall_fd = stall_fd_c & ~rst;
    assign bus.flush_fd = flush_fd_c & ~rst;
    assign bus.stall_de = stall_de_c & ~rst;
    assign bus.flush_de = flush_de_c & ~rst;
    assign bus.stall_em = stall_em_c & ~rst;

    assign lost_inc = bus.stall_fd | bus.flush_fd | bus.flush_de;

    // FSM state and pending-bubble counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    // Saturating lost-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost_q <= '0;
        end else if (lost_inc && (lost_q != '1)) begin
            lost_q <= lost_q + 1'b1;
        end
    end

    assign bus.lost_cycles = lost_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: instance A (1 bubble, 16-bit counter) runs
// a vector table; instance B (3 bubbles, 4-bit counter) covers multi-cycle
// bubble/wait interaction, saturation and reset during a memory wait.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst;
    logic [3:0] rs1, rs2, rd;
    logic rs2u, wbs, mm, br, busy;

    pipeline_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) if_a ();
    pipeline_hazard_ctrl_if #(.REG_W(4), .CNT_W(4))  if_b ();

    assign if_a.rs1_id = rs1;  assign if_b.rs1_id = rs1;
    assign if_a.rs2_id = rs2;  assign if_b.rs2_id = rs2;
    assign if_a.rs2_used_id = rs2u;  assign if_b.rs2_used_id = rs2u;
    assign if_a.rd_ex = rd;    assign if_b.rd_ex = rd;
    assign if_a.wbs_ex = wbs;  assign if_b.wbs_ex = wbs;
    assign if_a.mm_ex = mm;    assign if_b.mm_ex = mm;
    assign if_a.branch_taken_ex = br;  assign if_b.branch_taken_ex = br;
    assign if_a.mem_busy = busy;       assign if_b.mem_busy = busy;

    pipeline_hazard_ctrl #(.REG_W(4), .LOAD_STALL(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave)
    );
    pipeline_hazard_ctrl #(.REG_W(4), .LOAD_STALL(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector order: {stall_fd, flush_fd, stall_de, flush_de, stall_em}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_LU   = 5'b10010;
    localparam logic [4:0] C_BR   = 5'b01010;
    localparam logic [4:0] C_MEM  = 5'b10101;

    typedef struct {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       rs2u;
        logic [3:0] rd;
        logic       wbs;
        logic       mm;
        logic       br;
        logic       busy;
        logic [4:0] ctrl;
        int         lost;
        string      name;
    } vec_t;

    typedef struct {
        string      name;
        int         dut;
        logic [4:0] ctrl;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int failed = 0;
    int fde_cnt = 0;

    function automatic logic [4:0] get_ctrl(input int dut);
        if (dut == 0)
            return {if_a.stall_fd, if_a.flush_fd, if_a.stall_de, if_a.flush_de, if_a.stall_em};
        return {if_b.stall_fd, if_b.flush_fd, if_b.stall_de, if_b.flush_de, if_b.stall_em};
    endfunction

    function automatic int get_lost(input int dut);
        if (dut == 0) return int'(if_a.lost_cycles);
        return int'(if_b.lost_cycles);
    endfunction

    task automatic check(input string nm, input int act, input int exp_v);
        tests++;
        if (act !== exp_v) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end else begin
            $display("[TB] ok   %s: %0h", nm, act);
        end
    endtask

    // Drive one cycle of inputs, queue the expected controls, compare at the
    // falling edge, then advance past the next rising edge.
    task automatic step(input logic [3:0] r1, input logic [3:0] r2, input logic r2u,
                        input logic [3:0] d, input logic w, input logic m,
                        input logic b, input logic bz, input int dut,
                        input logic [4:0] exp_ctrl, input string nm);
        exp_t e;
        logic [4:0] act;
        rs1 = r1; rs2 = r2; rs2u = r2u; rd = d;
        wbs = w; mm = m; br = b; busy = bz;
        e.name = nm; e.dut = dut; e.ctrl = exp_ctrl;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        act = get_ctrl(e.dut);
        if (act[1]) fde_cnt++;
        check(e.name, int'(act), int'(e.ctrl));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1 = 0; rs2 = 0; rs2u = 0; rd = 0; wbs = 0; mm = 0; br = 0; busy = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 0, "idle"};
        tbl[1]  = '{4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, C_LU,   1, "lu_rs1"};
        tbl[2]  = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1, "after_lu"};
        tbl[3]  = '{4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_NONE, 1, "rd_zero"};
        tbl[4]  = '{4'd1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_NONE, 1, "rs2_unused"};
        tbl[5]  = '{4'd1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_LU,   2, "lu_rs2"};
        tbl[6]  = '{4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2, "alu_producer"};
        tbl[7]  = '{4'd3, 4'd0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, 2, "no_writeback"};
        tbl[8]  = '{4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, C_BR,   3, "branch_over_lu"};
        tbl[9]  = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_BR,   4, "branch"};
        tbl[10] = '{4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, C_MEM,  5, "busy_over_lu"};
        tbl[11] = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_MEM,  6, "busy"};
        tbl[12] = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_BR,   7, "release_branch"};
        tbl[13] = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 7, "idle2"};
        tbl[14] = '{4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, C_LU,   8, "lu_again"};
        tbl[15] = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 8, "idle3"};

        rst = 1'b1;
        idle_inputs();
        busy = 1'b1;   // outputs must still be low while reset is held
        #12;
        check("reset_ctrl_a", int'(get_ctrl(0)), 0);
        check("reset_ctrl_b", int'(get_ctrl(1)), 0);
        check("reset_lost_a", get_lost(0), 0);
        do_reset();

        // Table on instance A
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rs1, tbl[i].rs2, tbl[i].rs2u, tbl[i].rd, tbl[i].wbs,
                 tbl[i].mm, tbl[i].br, tbl[i].busy, 0, tbl[i].ctrl, tbl[i].name);
            check({tbl[i].name, "_lost"}, get_lost(0), tbl[i].lost);
        end

        // Memory wait of 4 cycles on A
        do_reset();
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM, "memwait");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, "memwait_release");
        check("memwait_lost", get_lost(0), 4);

        // Three bubbles on B with a 2-cycle wait during the second bubble
        do_reset();
        fde_cnt = 0;
        step(3, 0, 0, 3, 1, 1, 0, 0, 1, C_LU,   "ls3_bubble1");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, C_MEM,  "ls3_wait1");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, C_MEM,  "ls3_wait2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, "ls3_release");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, C_LU,   "ls3_bubble2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, C_LU,   "ls3_bubble3");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, "ls3_done");
        check("ls3_flush_de_count", fde_cnt, 3);
        check("ls3_lost", get_lost(1), 5);

        // Branch discards remaining bubbles on B
        do_reset();
        step(3, 0, 0, 3, 1, 1, 0, 0, 1, C_LU,   "ls3b_bubble1");
        step(0, 0, 0, 0, 0, 0, 1, 0, 1, C_BR,   "ls3b_branch");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, "ls3b_discarded");

        // Saturation of the 4-bit counter on B
        do_reset();
        for (int i = 0; i < 20; i++)
            step(0, 0, 0, 0, 0, 0, 0, 1, 1, C_MEM, "sat_wait");
        check("sat_lost", get_lost(1), 15);

        // Reset asserted mid-MEM_WAIT with bubbles pending on B
        do_reset();
        step(3, 0, 0, 3, 1, 1, 0, 0, 1, C_LU,  "rst_bubble1");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, C_MEM, "rst_wait");
        #2 rst = 1'b1;    // busy still high, between clock edges
        #1;
        check("rst_async_ctrl_b", int'(get_ctrl(1)), 0);
        check("rst_async_lost_b", get_lost(1), 0);
        @(negedge clk);
        idle_inputs();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, "rst_after1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, "rst_after2");
        check("rst_after_lost", get_lost(1), 0);

        if (exp_q.size() != 0) begin
            failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
